// File: rtl/reg_operand_ctrl_if.sv
// reg_operand_ctrl_if: instruction handshake plus register-file port bundle; master is the sequencer side.
interface reg_operand_ctrl_if;
  logic [31:0] INSTRUCTION;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  OUT1addr;
  logic [2:0]  OUT2addr;
  logic [7:0]  OUT1;
  logic [7:0]  OUT2;
  logic [7:0]  IN;
  logic [2:0]  INaddr;
  logic        WRITEEN;
  logic        busy;
  logic        done;
  logic        illegal;
  modport master (
    input  INSTRUCTION, instr_valid, OUT1, OUT2,
    output instr_ready, OUT1addr, OUT2addr, IN, INaddr, WRITEEN, busy, done, illegal
  );
  modport slave (
    output INSTRUCTION, instr_valid, OUT1, OUT2,
    input  instr_ready, OUT1addr, OUT2addr, IN, INaddr, WRITEEN, busy, done, illegal
  );
endinterface

// File: rtl/reg_operand_ctrl.sv
// reg_operand_ctrl: IDLE/READ/EXEC/WRITE sequencer driving an 8x8 register file.
// Define REG_OPERAND_FASTIMM_EN to send LOADI straight from accept to WRITE.
module reg_operand_ctrl (
  input logic clk,
  input logic RESET,
  reg_operand_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t state;
  logic [31:0] instr_q;
  logic [7:0] result_q, op, imm, alu;
  logic legal, unused_bits;
  assign op = instr_q[31:24];
  assign imm = instr_q[7:0];
  assign bus.OUT1addr = instr_q[10:8];
  assign bus.OUT2addr = instr_q[2:0];
  assign bus.INaddr = instr_q[18:16];
  assign bus.IN = result_q;
  assign unused_bits = ^{instr_q[23:19], instr_q[15:11]};
  assign legal = op < 8'd6;
  assign alu = op == 8'd0 ? imm :
               op == 8'd1 ? bus.OUT2 :
               op == 8'd2 ? bus.OUT1 + bus.OUT2 :
               op == 8'd3 ? bus.OUT1 - bus.OUT2 :
               op == 8'd4 ? bus.OUT1 & bus.OUT2 : bus.OUT1 | bus.OUT2;
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state <= IDLE;
      instr_q <= '0;
      result_q <= '0;
      bus.instr_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.illegal <= 1'b0;
      bus.WRITEEN <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.WRITEEN <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid && bus.instr_ready) begin
            instr_q <= bus.INSTRUCTION;
            bus.illegal <= 1'b0;
            bus.instr_ready <= 1'b0;
            bus.busy <= 1'b1;
            state <= READ;
`ifdef REG_OPERAND_FASTIMM_EN
            if (bus.INSTRUCTION[31:24] == 8'h00) begin
              result_q <= bus.INSTRUCTION[7:0];
              bus.WRITEEN <= 1'b1;
              state <= WRITE;
            end
`endif
          end else begin
            bus.instr_ready <= 1'b1;
          end
        end
        READ: state <= EXEC;
        EXEC: begin
          if (legal) begin
            result_q <= alu;
            bus.WRITEEN <= 1'b1;
            state <= WRITE;
          end else begin
            bus.illegal <= 1'b1;
            bus.done <= 1'b1;
            bus.instr_ready <= 1'b1;
            bus.busy <= 1'b0;
            state <= IDLE;
          end
        end
        WRITE: begin
          bus.done <= 1'b1;
          bus.instr_ready <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_operand_ctrl.sv
// tb_reg_operand_ctrl: directed vectors against a behavioural 8x8 register file (r_i = i at power-up).
module tb_reg_operand_ctrl;
  logic clk = 1'b0;
  logic RESET;
  int checks = 0;
  int errors = 0;
  logic [7:0] rf [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  reg_operand_ctrl_if bus ();
  reg_operand_ctrl dut (.clk(clk), .RESET(RESET), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.OUT1 <= rf[bus.OUT1addr];
    bus.OUT2 <= rf[bus.OUT2addr];
  end
  always @(negedge clk) if (bus.WRITEEN) rf[bus.INaddr] <= bus.IN;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input string tag, input logic [31:0] ins);
    int n = 0;
    bus.INSTRUCTION = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      step;
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(n < 20), 1);
    step;
    bus.instr_valid = 1'b0;
  endtask
  task automatic run(input string tag, input logic [31:0] ins, input logic [7:0] exp_in, input logic [2:0] exp_addr);
    issue(tag, ins);
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_ready0"}, bus.instr_ready, 0);
    chk({tag, "_illegal"}, bus.illegal, 0);
    chk({tag, "_we_read"}, bus.WRITEEN, 0);
    step;
    chk({tag, "_we_exec"}, bus.WRITEEN, 0);
    chk({tag, "_done_exec"}, bus.done, 0);
    step;
    chk({tag, "_we"}, bus.WRITEEN, 1);
    chk({tag, "_in"}, bus.IN, exp_in);
    chk({tag, "_inaddr"}, bus.INaddr, exp_addr);
    chk({tag, "_done_write"}, bus.done, 0);
    step;
    chk({tag, "_we_after"}, bus.WRITEEN, 0);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_ready1"}, bus.instr_ready, 1);
    chk({tag, "_busy0"}, bus.busy, 0);
  endtask
  task automatic loadi(input string tag, input logic [31:0] ins, input logic [7:0] exp_in, input logic [2:0] exp_addr);
`ifdef REG_OPERAND_FASTIMM_EN
    issue(tag, ins);
    chk({tag, "_we"}, bus.WRITEEN, 1);
    chk({tag, "_in"}, bus.IN, exp_in);
    chk({tag, "_inaddr"}, bus.INaddr, exp_addr);
    chk({tag, "_done_write"}, bus.done, 0);
    step;
    chk({tag, "_we_after"}, bus.WRITEEN, 0);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_ready1"}, bus.instr_ready, 1);
`else
    run(tag, ins, exp_in, exp_addr);
`endif
  endtask
  task automatic reset_chk(input string tag);
    chk({tag, "_ready"}, bus.instr_ready, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_illegal"}, bus.illegal, 0);
    chk({tag, "_we"}, bus.WRITEEN, 0);
    chk({tag, "_in"}, bus.IN, 0);
    chk({tag, "_inaddr"}, bus.INaddr, 0);
    chk({tag, "_out1addr"}, bus.OUT1addr, 0);
    chk({tag, "_out2addr"}, bus.OUT2addr, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    RESET = 1'b0;
    bus.instr_valid = 1'b0;
    bus.INSTRUCTION = '0;
    step;
    step;
    reset_chk("por");
    RESET = 1'b1;
    step;
    chk("por_ready_rise", bus.instr_ready, 1);
    run("add", 32'h02060305, 8'h08, 3'd6);
    chk("rf6", rf[6], 8'h08);
    issue("ill", 32'h09010203);
    chk("ill_clr", bus.illegal, 0);
    chk("ill_we_read", bus.WRITEEN, 0);
    step;
    chk("ill_we_exec", bus.WRITEEN, 0);
    chk("ill_done_exec", bus.done, 0);
    step;
    chk("ill_done", bus.done, 1);
    chk("ill_flag", bus.illegal, 1);
    chk("ill_we", bus.WRITEEN, 0);
    chk("ill_ready", bus.instr_ready, 1);
    step;
    chk("ill_done_pulse", bus.done, 0);
    chk("ill_sticky", bus.illegal, 1);
    chk("ill_we_after", bus.WRITEEN, 0);
    run("mov", 32'h01000001, 8'h01, 3'd0);
    chk("rf0", rf[0], 8'h01);
    run("sub", 32'h03010207, 8'hFB, 3'd1);
    loadi("loadi_ff", 32'h000400FF, 8'hFF, 3'd4);
    run("add_wrap", 32'h02040404, 8'hFE, 3'd4);
    chk("b2b_ready_pre", bus.instr_ready, 1);
    bus.INSTRUCTION = 32'h02020303;
    bus.instr_valid = 1'b1;
    step;
    bus.INSTRUCTION = 32'h02050206;
    chk("b2b_busy", bus.busy, 1);
    step;
    chk("b2b_ready_busy", bus.instr_ready, 0);
    step;
    chk("b2b_we1", bus.WRITEEN, 1);
    chk("b2b_in1", bus.IN, 8'h06);
    chk("b2b_addr1", bus.INaddr, 3'd2);
    step;
    chk("b2b_done1", bus.done, 1);
    chk("b2b_ready_done", bus.instr_ready, 1);
    step;
    bus.instr_valid = 1'b0;
    chk("b2b_accept4", bus.busy, 1);
    chk("b2b_ready_after", bus.instr_ready, 0);
    chk("b2b_done_off", bus.done, 0);
    step;
    step;
    chk("b2b_we2", bus.WRITEEN, 1);
    chk("b2b_in2", bus.IN, 8'h0E);
    chk("b2b_addr2", bus.INaddr, 3'd5);
    step;
    chk("b2b_done2", bus.done, 1);
    issue("rst_and", 32'h04020307);
    step;
    RESET = 1'b0;
    step;
    reset_chk("rst_exec");
    RESET = 1'b1;
    step;
    chk("rst_exec_ready", bus.instr_ready, 1);
    chk("rst_exec_we", bus.WRITEEN, 0);
    chk("rf2_kept", rf[2], 8'h06);
    loadi("loadi_42", 32'h00050042, 8'h42, 3'd5);
    chk("rf5", rf[5], 8'h42);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
